// File: rtl/ciccio_pkg.sv
// rtl/ciccio_pkg.sv - shared slot state type and default sizing for the ciccio demux
//   exports: slot_state_e (EMPTY, FULL), DEFAULT_WIDTH, DEFAULT_CNT_W
package ciccio_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/ciccio_slot.sv
// rtl/ciccio_slot.sv - one-entry output register slot with delivered-word counter
//   clk, reset       : clock, asynchronous active-high reset
//   load, load_data  : write a word into the slot this cycle
//   can_load         : slot can take a word this cycle (empty, or draining now)
//   out_valid/ready  : downstream handshake; out_data holds the slot payload
//   cnt              : words delivered downstream, wraps at 2^CNT_W
module ciccio_slot
  import ciccio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             can_load,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);

  slot_state_e state;
  slot_state_e state_nxt;
  logic        drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A slot that drains this cycle can be refilled in the same cycle, so
  // a steady stream passes with no bubble.
  always_comb begin
    state_nxt = state;
    drain     = (state == FULL) && out_ready;
    can_load  = (state == EMPTY) || out_ready;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (drain && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: rtl/ciccio_demux.sv
// rtl/ciccio_demux.sv - 1-to-2 stream demultiplexer with a register slot per output
//   clk, reset                         : clock, asynchronous active-high reset
//   io_in_valid/ready/data, io_sel     : upstream word and its destination (0 -> out0, 1 -> out1)
//   io_outN_valid/ready/data           : downstream handshake per output
//   io_cntN                            : words delivered on output N
module ciccio_demux
  import ciccio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_data,
  input  logic             io_sel,
  output logic             io_out0_valid,
  input  logic             io_out0_ready,
  output logic [WIDTH-1:0] io_out0_data,
  output logic             io_out1_valid,
  input  logic             io_out1_ready,
  output logic [WIDTH-1:0] io_out1_data,
  output logic [CNT_W-1:0] io_cnt0,
  output logic [CNT_W-1:0] io_cnt1
);

  logic can_load0;
  logic can_load1;
  logic in_xfer;

  // Ready looks only at the addressed slot, so a stalled output never
  // blocks traffic headed for the other one.
  assign io_in_ready = !reset && (io_sel ? can_load1 : can_load0);
  assign in_xfer     = io_in_valid && io_in_ready;

  ciccio_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (in_xfer && !io_sel),
    .load_data (io_in_data),
    .out_ready (io_out0_ready),
    .can_load  (can_load0),
    .out_valid (io_out0_valid),
    .out_data  (io_out0_data),
    .cnt       (io_cnt0)
  );

  ciccio_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (in_xfer && io_sel),
    .load_data (io_in_data),
    .out_ready (io_out1_ready),
    .can_load  (can_load1),
    .out_valid (io_out1_valid),
    .out_data  (io_out1_data),
    .cnt       (io_cnt1)
  );

endmodule

// File: tb/tb_ciccio_demux.sv
// tb/tb_ciccio_demux.sv - self-checking bench for ciccio_demux
module tb_ciccio_demux;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       sel;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out0_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out1_data;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int vectors;
  int miscompares;

  ciccio_demux #(.WIDTH(8), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_in_valid   (in_valid),
    .io_in_ready   (in_ready),
    .io_in_data    (in_data),
    .io_sel        (sel),
    .io_out0_valid (out0_valid),
    .io_out0_ready (out0_ready),
    .io_out0_data  (out0_data),
    .io_out1_valid (out1_valid),
    .io_out1_ready (out1_ready),
    .io_out1_data  (out1_data),
    .io_cnt0       (cnt0),
    .io_cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Applies one cycle of inputs just after a rising edge and returns at the
  // falling edge; the handshake completes on the following rising edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic s,
                       input logic r0, input logic r1);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_data    = d;
    sel        = s;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF; sel = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: actual=%b required=0", in_ready); end
    vectors++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_valid: actual=%b%b required=00", out0_valid, out1_valid);
    end
    vectors++;
    if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
      miscompares++; $display("FAIL rst_data: actual=%h/%h required=00/00", out0_data, out1_data);
    end
    vectors++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      miscompares++; $display("FAIL rst_cnt: actual=%0d/%0d required=0/0", cnt0, cnt1);
    end
    in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: actual=%b required=1", in_ready); end
  endtask

  task automatic test_single;
    test_reset();
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: actual=%b required=1", in_ready); end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
      miscompares++; $display("FAIL single_out0: actual=%b/%h required=1/a5", out0_valid, out0_data);
    end
    vectors++;
    if (out1_valid !== 1'b0) begin miscompares++; $display("FAIL single_out1: actual=%b required=0", out1_valid); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (cnt0 !== 8'd1 || out0_valid !== 1'b0 || cnt1 !== 8'd0) begin
      miscompares++; $display("FAIL single_cnt: actual=%0d/%b/%0d required=1/0/0", cnt0, out0_valid, cnt1);
    end
  endtask

  task automatic test_backpressure;
    test_reset();
    drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_first_ready: actual=%b required=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (in_ready !== 1'b0 || out1_valid !== 1'b1 || out1_data !== 8'h11) begin
        miscompares++;
        $display("FAIL bp_stall: actual=%b/%b/%h required=0/1/11", in_ready, out1_valid, out1_data);
      end
    end
    drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (in_ready !== 1'b1 || out1_data !== 8'h11) begin
      miscompares++; $display("FAIL bp_release: actual=%b/%h required=1/11", in_ready, out1_data);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h22) begin
      miscompares++; $display("FAIL bp_second: actual=%b/%h required=1/22", out1_valid, out1_data);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out1_valid !== 1'b0 || cnt1 !== 8'd2 || cnt0 !== 8'd0) begin
      miscompares++; $display("FAIL bp_done: actual=%b/%0d/%0d required=0/2/0", out1_valid, cnt1, cnt0);
    end
  endtask

  task automatic test_back_to_back;
    test_reset();
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (in_ready !== 1'b1 || out0_data !== 8'h44 || out1_data !== 8'h55) begin
      miscompares++;
      $display("FAIL b2b_accept: actual=%b/%h/%h required=1/44/55", in_ready, out0_data, out1_data);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h33 || cnt0 !== 8'd1) begin
      miscompares++; $display("FAIL b2b_out0: actual=%b/%h/%0d required=1/33/1", out0_valid, out0_data, cnt0);
    end
    vectors++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h55 || cnt1 !== 8'd0) begin
      miscompares++; $display("FAIL b2b_out1: actual=%b/%h/%0d required=1/55/0", out1_valid, out1_data, cnt1);
    end
  endtask

  task automatic test_wrap;
    test_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      vectors++;
      if (in_ready !== 1'b1 || cnt0 !== 8'((i == 0) ? 0 : i - 1)) begin
        miscompares++;
        $display("FAIL wrap_stream[%0d]: actual=%b/%0d required=1/%0d", i, in_ready, cnt0, (i == 0) ? 0 : i - 1);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (cnt0 !== 8'd255 || out0_data !== 8'hFF) begin
      miscompares++; $display("FAIL wrap_max: actual=%0d/%h required=255/ff", cnt0, out0_data);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      miscompares++; $display("FAIL wrap_zero: actual=%0d/%0d required=0/0", cnt0, cnt1);
    end
  endtask

  task automatic test_reset_mid;
    test_reset();
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_rst: actual=%b%b/%0d/%0d required=00/0/0", out0_valid, out1_valid, cnt0, cnt1);
    end
    out1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
        miscompares++;
        $display("FAIL mid_rst_after[%0d]: actual=%b%b/%0d/%0d required=00/0/0", i, out0_valid, out1_valid, cnt0, cnt1);
      end
    end
  endtask

  // Reference: each output keeps a queue of words accepted but not yet
  // delivered; the demux may hold at most one per output.
  task automatic test_random;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         dlv0;
    int         dlv1;
    logic       v, s, r0, r1, exp_ready;
    logic [7:0] d;
    test_reset();
    dlv0 = 0;
    dlv1 = 0;
    for (int c = 0; c < 10000; c++) begin
      v  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) == 0);
      d  = 8'($urandom);
      drive(v, d, s, r0, r1);
      exp_ready = s ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++; $display("FAIL rnd_ready@%0d: actual=%b required=%b", c, in_ready, exp_ready);
      end
      vectors++;
      if (out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0)) begin
        miscompares++;
        $display("FAIL rnd_valid@%0d: actual=%b%b required=%b%b", c, out0_valid, out1_valid,
                 q0.size() != 0, q1.size() != 0);
      end
      if (q0.size() != 0) begin
        vectors++;
        if (out0_data !== q0[0]) begin miscompares++; $display("FAIL rnd_data0@%0d: actual=%h required=%h", c, out0_data, q0[0]); end
      end
      if (q1.size() != 0) begin
        vectors++;
        if (out1_data !== q1[0]) begin miscompares++; $display("FAIL rnd_data1@%0d: actual=%h required=%h", c, out1_data, q1[0]); end
      end
      vectors++;
      if (cnt0 !== 8'(dlv0) || cnt1 !== 8'(dlv1)) begin
        miscompares++; $display("FAIL rnd_cnt@%0d: actual=%0d/%0d required=%0d/%0d", c, cnt0, cnt1, dlv0 % 256, dlv1 % 256);
      end
      if (q0.size() != 0 && r0) begin void'(q0.pop_front()); dlv0++; end
      if (q1.size() != 0 && r1) begin void'(q1.pop_front()); dlv1++; end
      if (v && exp_ready) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    sel         = 1'b0;
    out0_ready  = 1'b0;
    out1_ready  = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ciccio_demux.md
CICCIO_DEMUX -- requirements
Module: ciccio_demux

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits.
REQ-002 Parameter CNT_W, default 8: width of each per-output transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_in_valid  input  1  upstream word present.
REQ-006 io_in_ready  output  1  demux accepts word this cycle.
REQ-007 io_in_data  input  WIDTH  upstream payload.
REQ-008 io_sel  input  1  destination of current input word; 0 selects out0, 1 selects out1.
REQ-009 io_out0_valid / io_out1_valid  output  1  output slot holds a word.
REQ-010 io_out0_ready / io_out1_ready  input  1  downstream consumes the word.
REQ-011 io_out0_data / io_out1_data  output  WIDTH  slot payload.
REQ-012 io_cnt0 / io_cnt1  output  CNT_W  words delivered on each output.

Function
REQ-013 Each output SHALL own one slot with states EMPTY and FULL.
REQ-014 Input transfer SHALL occur when io_in_valid and io_in_ready are both 1.
REQ-015 io_in_ready SHALL be 1 iff the slot addressed by io_sel is EMPTY, or that slot is FULL and its downstream ready is 1 in the same cycle; io_in_ready SHALL depend combinationally only on io_sel and state/ready of the addressed slot.
REQ-016 On input transfer, the addressed slot SHALL load io_in_data and be FULL on the next cycle: latency is 1 cycle from input transfer to valid on the output.
REQ-017 Slot FULL with downstream ready=1 and no new load SHALL go EMPTY next cycle.
REQ-018 Simultaneous drain and load of the same slot SHALL leave it FULL with the new data, with no bubble.
REQ-019 A slot's data SHALL stay stable while FULL and not drained.
REQ-020 Output valid SHALL equal slot FULL; output data while EMPTY is don't-care but SHALL not produce X after reset.
REQ-021 The non-addressed slot SHALL drain independently in the same cycle as a load of the other slot.
REQ-022 io_cntN SHALL increment by 1 on every output transfer (valid and ready both 1) and wrap from 2^CNT_W-1 to 0.
REQ-023 A word SHALL never be dropped or duplicated; order per output SHALL equal input order for that destination.
REQ-024 io_sel while io_in_valid=0 SHALL have no effect.

Reset
REQ-025 While reset=1, both slots SHALL be EMPTY, io_out0_valid=io_out1_valid=0, slot data=0, io_cnt0=io_cnt1=0, asynchronously on assertion.
REQ-026 Reset asserted mid-operation SHALL discard held words; no transfer SHALL complete in a cycle where reset is high.
REQ-027 io_in_ready SHALL be 0 while reset is high.

Structure
REQ-028 Package ciccio_pkg SHALL hold the slot state enum (EMPTY, FULL) and default WIDTH/CNT_W constants.
REQ-029 Sub-module ciccio_slot (one-entry register slot plus its counter) SHALL be instantiated twice; top level holds only routing and ready logic.

Verification
REQ-030 Reset, then send 0xA5 with sel=0, out0_ready=1 -> out0_valid=1 with 0xA5 one cycle later; cnt0=1; out1_valid stays 0.
REQ-031 out1_ready=0, send 0x11 then 0x22 with sel=1 -> first accepted, in_ready=0 for second until out1_ready=1; 0x11 then 0x22 delivered in order.
REQ-032 Both outputs full, out0_ready=1, input 0x33 sel=0 -> 0x33 accepted same cycle as drain; out0 stays valid, no bubble; out1 unchanged.
REQ-033 Continuous 256 transfers on out0 with CNT_W=8 -> cnt0 wraps to 0; cnt1 remains 0.
REQ-034 Assert reset while both slots FULL -> outputs valid=0 immediately, counters 0, previous data never delivered after release.
REQ-035 Random valid/ready/sel for 10000 cycles with scoreboard -> no loss, duplication, or reordering per output; counters match scoreboard.
